// File: rtl/frame_scan_sequencer_if.sv
// Bus bundle between frame_scan_sequencer (master) and the capture/datapath side (slave).
interface frame_scan_sequencer_if #(
  parameter int ADDR_BITS = 17
);
  logic                 frame_ready;
  logic                 scan_enable;
  logic [ADDR_BITS-1:0] rdaddress;
  logic                 rd_en;
  logic                 pix_valid;
  logic                 frame_start;
  logic                 frame_end;
  logic [6:0]           direction_in;
  logic [6:0]           direction_out;
  logic                 direction_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    input  frame_ready, scan_enable, direction_in,
    output rdaddress, rd_en, pix_valid, frame_start, frame_end,
           direction_out, direction_valid, busy, overrun
  );

  modport slave (
    output frame_ready, scan_enable, direction_in,
    input  rdaddress, rd_en, pix_valid, frame_start, frame_end,
           direction_out, direction_valid, busy, overrun
  );
endinterface

// File: rtl/frame_scan_sequencer.sv
// Sweeps the frame BRAM once per accepted frame_ready and reports the datapath heading.
// Optional macro DIR_SMOOTH_EN: average each new heading with the previous report.
module frame_scan_sequencer #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
  parameter int RD_LATENCY   = 2,
  parameter int DIR_LATENCY  = 3,
  parameter int DECIMATE     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  frame_scan_sequencer_if.master  bus
);
  localparam int NPIX     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int DEC_BITS = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int MAX_LAT  = (RD_LATENCY > DIR_LATENCY) ? RD_LATENCY : DIR_LATENCY;
  localparam int CNT_BITS = $clog2(MAX_LAT + 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, SETTLE, REPORT} state_t;

  state_t               state_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic                 rd_en_reg;
  logic                 busy_reg;
  logic                 dv_reg;
  logic [6:0]           dir_reg;
  logic [6:0]           dir_next;
  logic [DEC_BITS-1:0]  dec_reg;
  logic [CNT_BITS-1:0]  cnt_reg;
  logic                 settle_done;
  logic [RD_LATENCY-1:0] pv_pipe, fs_pipe, fe_pipe;

  assign settle_done = (state_reg == SETTLE) && (cnt_reg == CNT_BITS'(DIR_LATENCY - 1));

`ifdef DIR_SMOOTH_EN
  logic       first_reg;
  logic [7:0] dir_sum;
  assign dir_sum  = {1'b0, dir_reg} + {1'b0, bus.direction_in};
  assign dir_next = first_reg ? bus.direction_in : 7'(dir_sum >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n)           first_reg <= 1'b1;
    else if (settle_done) first_reg <= 1'b0;
  end
`else
  assign dir_next = bus.direction_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      rd_en_reg <= 1'b0;
      busy_reg  <= 1'b0;
      dv_reg    <= 1'b0;
      dir_reg   <= '0;
      dec_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      dv_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          addr_reg <= '0;
          if (bus.frame_ready && bus.scan_enable) begin
            if (dec_reg == DEC_BITS'(DECIMATE - 1)) begin
              dec_reg   <= '0;
              state_reg <= SCAN;
              rd_en_reg <= 1'b1;
              busy_reg  <= 1'b1;
            end else begin
              dec_reg <= dec_reg + 1'b1;
            end
          end
        end
        SCAN: begin
          if (addr_reg == LAST_ADDR) begin
            state_reg <= DRAIN;
            rd_en_reg <= 1'b0;
            addr_reg  <= '0;
            cnt_reg   <= '0;
          end else begin
            addr_reg <= addr_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_reg == CNT_BITS'(RD_LATENCY - 1)) begin
            state_reg <= SETTLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            state_reg <= REPORT;
            dv_reg    <= 1'b1;
            dir_reg   <= dir_next;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        REPORT: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Markers ride alongside rd_en so they line up with the BRAM data they describe.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pv_pipe[gi] <= 1'b0;
          fs_pipe[gi] <= 1'b0;
          fe_pipe[gi] <= 1'b0;
        end else if (gi == 0) begin
          pv_pipe[gi] <= rd_en_reg;
          fs_pipe[gi] <= rd_en_reg && (addr_reg == '0);
          fe_pipe[gi] <= rd_en_reg && (addr_reg == LAST_ADDR);
        end else begin
          pv_pipe[gi] <= pv_pipe[(gi > 0) ? gi - 1 : 0];
          fs_pipe[gi] <= fs_pipe[(gi > 0) ? gi - 1 : 0];
          fe_pipe[gi] <= fe_pipe[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign bus.rdaddress       = addr_reg;
  assign bus.rd_en           = rd_en_reg;
  assign bus.pix_valid       = pv_pipe[RD_LATENCY-1];
  assign bus.frame_start     = fs_pipe[RD_LATENCY-1];
  assign bus.frame_end       = fe_pipe[RD_LATENCY-1];
  assign bus.direction_out   = dir_reg;
  assign bus.direction_valid = dv_reg;
  assign bus.busy            = busy_reg;
  // Dropped frames are flagged in the very cycle they arrive.
  assign bus.overrun         = bus.frame_ready & busy_reg;
endmodule
